// File: rtl/muxn_scan_pkg.sv
// Shared types and helpers for the scanning N:1 mux.
package muxn_scan_pkg;

  // Operating state: external select or internal round-robin pointer.
  typedef enum logic [0:0] {
    StManual,
    StScan
  } state_e;

  // Out-of-range selects collapse to channel 0 when seeding the scan pointer.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned n_ch);
    return (sel < n_ch) ? sel : 32'd0;
  endfunction

endpackage

// File: rtl/muxn_comb.sv
// Purely combinational N_CH x WIDTH mux; an index with no matching channel yields zero.
module muxn_comb #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned SELW  = $clog2(N_CH)
) (
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      y
);

  // Compare against each legal index so out-of-range bits of din are never addressed.
  always_comb begin
    y = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (sel == SELW'(k)) begin
        y = din[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/muxn_scan.sv
// Registered N:1 mux with manual select and a dwell-based round-robin scan mode.
module muxn_scan
  import muxn_scan_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DWELL = 8,
  localparam int unsigned SELW = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  input  logic                  en,
  output logic [WIDTH-1:0]      y,
  output logic [SELW-1:0]       ch_out,
  output logic                  y_valid,
  output logic                  wrap,
  output logic                  sel_err
);

  localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CntLast = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] PtrLast = SELW'(N_CH - 1);

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic              vld_q, vld_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  logic              sel_oob;
  logic [SELW-1:0]   load_ptr;
  logic [SELW-1:0]   mux_sel;
  logic [WIDTH-1:0]  mux_y;

  assign sel_oob  = (32'(sel) >= N_CH);
  assign load_ptr = SELW'(clamp_sel(32'(sel), N_CH));

  // Pick the index feeding the mux: manual select, freshly seeded pointer, or live pointer.
  always_comb begin
    mux_sel = sel;
    if (mode) begin
      mux_sel = (state_q == StManual) ? load_ptr : ptr_q;
    end
  end

  muxn_comb #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_mux (
    .din (din),
    .sel (mux_sel),
    .y   (mux_y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StManual;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows mode, but only on enabled cycles.
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = mode ? StScan : StManual;
    end
  end

  // Next values for the sample, tag, pointer and dwell counter.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    y_d    = y_q;
    ch_d   = ch_q;
    err_d  = err_q;
    vld_d  = 1'b0;
    wrap_d = 1'b0;
    if (en) begin
      vld_d = 1'b1;
      y_d   = mux_y;
      if (!mode) begin
        ch_d  = sel;
        err_d = sel_oob;
        cnt_d = '0;
      end else if (state_q == StManual) begin
        ptr_d = load_ptr;
        cnt_d = '0;
        ch_d  = load_ptr;
        err_d = 1'b0;
      end else begin
        // Sample comes from the current pointer even on the edge that advances it.
        ch_d = ptr_q;
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (ptr_q == PtrLast) begin
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_q + SELW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign y       = y_q;
  assign ch_out  = ch_q;
  assign y_valid = vld_q;
  assign wrap    = wrap_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_muxn_scan.sv
// Directed bench: three builds (4ch/dwell3, 3ch/dwell3, 4ch/dwell1) driven in lockstep,
// expected outputs queued from a behavioural model and popped after each edge.
module tb_muxn_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode;
  logic [1:0] sel;

  logic [31:0] din4 = 32'hDDCCBBAA;
  logic [23:0] din3 = 24'hCCBBAA;

  logic [7:0] y_a, y_b, y_c;
  logic [1:0] ch_a, ch_b, ch_c;
  logic       v_a, v_b, v_c, w_a, w_b, w_c, e_a, e_b, e_c;

  muxn_scan #(.N_CH(4), .WIDTH(8), .DWELL(3)) u_a (
    .clk(clk), .rst(rst), .din(din4), .sel(sel), .mode(mode), .en(en),
    .y(y_a), .ch_out(ch_a), .y_valid(v_a), .wrap(w_a), .sel_err(e_a)
  );
  muxn_scan #(.N_CH(3), .WIDTH(8), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .din(din3), .sel(sel), .mode(mode), .en(en),
    .y(y_b), .ch_out(ch_b), .y_valid(v_b), .wrap(w_b), .sel_err(e_b)
  );
  muxn_scan #(.N_CH(4), .WIDTH(8), .DWELL(1)) u_c (
    .clk(clk), .rst(rst), .din(din4), .sel(sel), .mode(mode), .en(en),
    .y(y_c), .ch_out(ch_c), .y_valid(v_c), .wrap(w_c), .sel_err(e_c)
  );

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] ch;
    logic       v;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int   ncfg[3] = '{4, 3, 4};
  int   dcfg[3] = '{3, 3, 1};
  int   m_scan[3], m_ptr[3], m_cnt[3];
  exp_t m_out[3];

  function automatic logic [7:0] chan(input int k);
    return 8'hAA + 8'(8'h11 * k);
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s inst%0d got=%0h exp=%0h", tag, i, got, exp);
    end
  endtask

  // Advance the model of instance i by one clock edge.
  task automatic model(input int i, input bit r, input bit e, input bit md, input int s);
    int n = ncfg[i];
    int p;
    m_out[i].v = 1'b0;
    m_out[i].w = 1'b0;
    if (r) begin
      m_out[i] = '0;
      m_scan[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
    end else if (e) begin
      m_out[i].v = 1'b1;
      if (!md) begin
        m_scan[i] = 0;
        m_cnt[i] = 0;
        m_out[i].ch = 2'(s);
        m_out[i].y = (s < n) ? chan(s) : 8'h00;
        m_out[i].e = (s >= n);
      end else if (m_scan[i] == 0) begin
        m_scan[i] = 1;
        p = (s < n) ? s : 0;
        m_ptr[i] = p; m_cnt[i] = 0;
        m_out[i].ch = 2'(p);
        m_out[i].y = chan(p);
        m_out[i].e = 1'b0;
      end else begin
        m_out[i].ch = 2'(m_ptr[i]);
        m_out[i].y = chan(m_ptr[i]);
        if (m_cnt[i] == dcfg[i] - 1) begin
          m_cnt[i] = 0;
          if (m_ptr[i] == n - 1) begin
            m_ptr[i] = 0;
            m_out[i].w = 1'b1;
          end else begin
            m_ptr[i]++;
          end
        end else begin
          m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit md, input int s);
    exp_t ex, ob;
    rst = r; en = e; mode = md; sel = 2'(s);
    for (int i = 0; i < 3; i++) begin
      model(i, r, e, md, s);
      sb.push_back(m_out[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      ex = sb.pop_front();
      case (i)
        0: ob = {y_a, ch_a, v_a, w_a, e_a};
        1: ob = {y_b, ch_b, v_b, w_b, e_b};
        default: ob = {y_c, ch_c, v_c, w_c, e_c};
      endcase
      chk("y", i, 32'(ob.y), 32'(ex.y));
      chk("ch_out", i, 32'(ob.ch), 32'(ex.ch));
      chk("y_valid", i, 32'(ob.v), 32'(ex.v));
      chk("wrap", i, 32'(ob.w), 32'(ex.w));
      chk("sel_err", i, 32'(ob.e), 32'(ex.e));
    end
  endtask

  logic [7:0] scan_seq[12] = '{8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hCC,
                               8'hDD, 8'hDD, 8'hDD, 8'hAA, 8'hAA, 8'hAA};
  int wraps;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0;
    // Reset state.
    step(1, 0, 0, 0);
    step(1, 1, 1, 2);
    chk("rst_valid", 0, 32'(v_a), 32'd0);

    // Manual select, including an invalid index on the 3-channel build.
    step(0, 1, 0, 2);
    chk("man_y_sel2", 0, 32'(y_a), 32'hCC);
    chk("man_ch_sel2", 0, 32'(ch_a), 32'd2);
    step(0, 1, 0, 0);
    chk("man_y_sel0", 0, 32'(y_a), 32'hAA);
    step(0, 1, 0, 3);
    chk("inv_y", 1, 32'(y_b), 32'h00);
    chk("inv_err", 1, 32'(e_b), 32'd1);
    step(0, 1, 1, 3);
    chk("inv_scan_y", 1, 32'(y_b), 32'hAA);
    chk("inv_scan_err", 1, 32'(e_b), 32'd0);

    // Scan from sel=1: entry sample, then 12 steady enabled cycles.
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    chk("entry_y", 0, 32'(y_a), 32'hBB);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 1, 1);
      chk("scan_y", 0, 32'(y_a), 32'(scan_seq[k]));
      chk("scan_wrap", 0, 32'(w_a), (k == 8) ? 32'd1 : 32'd0);
    end

    // Enable gating mid-dwell.
    step(0, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, (k % 2 == 0) ? 1'b0 : 1'b1, 3);
      chk("gate_y", 0, 32'(y_a), 32'hBB);
      chk("gate_valid", 0, 32'(v_a), 32'd0);
    end
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    chk("resume_y", 0, 32'(y_a), 32'hBB);
    step(0, 1, 1, 1);
    chk("resume_adv_y", 0, 32'(y_a), 32'hCC);

    // Reset mid-scan, then restart scan from sel.
    step(1, 1, 1, 1);
    chk("midrst_y", 0, 32'(y_a), 32'h00);
    chk("midrst_ch", 0, 32'(ch_a), 32'd0);
    step(0, 1, 1, 2);
    chk("restart_y", 0, 32'(y_a), 32'hCC);
    chk("restart_ch", 0, 32'(ch_a), 32'd2);

    // DWELL=1 build: pointer moves every enabled cycle.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    wraps = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 1, 0);
      chk("d1_ch", 2, 32'(ch_c), 32'(k % 4));
      if (w_c === 1'b1) wraps++;
    end
    chk("d1_wraps", 2, 32'(wraps), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
